// File: rtl/mac_pipe.sv
// Pipelined signed multiply-accumulate with guard bits, saturation and a dual-lane SIMD mode.
// Stages: S1 holds products/opcode, S2 holds the accumulator, then a registered output stage.
module mac_pipe #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 32,
  parameter int GUARD_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               in_valid,
  input  logic [2:0]         instruction,
  input  logic [DATA_W-1:0]  multiplier,
  input  logic [DATA_W-1:0]  multiplicand,
  output logic [ACC_W-1:0]   result,
  output logic [GUARD_W-1:0] protect,
  output logic               out_valid,
  output logic               overflow
);

  localparam int H  = DATA_W / 2;
  localparam int FW = ACC_W + GUARD_W;
  localparam int LA = ACC_W / 2;
  localparam int LG = GUARD_W / 2;
  localparam int LW = LA + LG;

  localparam logic signed [FW:0] SAT_MAX  = {{(FW-ACC_W+2){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [FW:0] SAT_MIN  = {{(FW-ACC_W+2){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [LW:0] LANE_MAX = {{(LW-LA+2){1'b0}}, {(LA-1){1'b1}}};
  localparam logic signed [LW:0] LANE_MIN = {{(LW-LA+2){1'b1}}, {(LA-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_CLR   = 3'b000,
    OP_MUL   = 3'b001,
    OP_MAC   = 3'b010,
    OP_MACS  = 3'b011,
    OP_CLR2  = 3'b100,
    OP_DMUL  = 3'b101,
    OP_DMAC  = 3'b110,
    OP_DMACS = 3'b111
  } op_e;

  logic                   s1Valid_q;
  op_e                    s1Op_q;
  logic [2*DATA_W-1:0]    s1Prod_q,  s1Prod_d;
  logic [DATA_W-1:0]      s1LaneProd_q [2];
  logic [DATA_W-1:0]      s1LaneProd_d [2];

  logic [FW-1:0]          acc_q, acc_d;
  logic                   s2Valid_q;
  logic                   s2Ovf_q, s2Ovf_d;

  logic [ACC_W-1:0]       result_q;
  logic [GUARD_W-1:0]     protect_q;
  logic                   outValid_q;
  logic                   overflow_q;

  logic [2*DATA_W-1:0]    aExt, bExt;
  logic [DATA_W-1:0]      aLane [2];
  logic [DATA_W-1:0]      bLane [2];

  logic [FW-1:0]          prodExt;
  logic signed [FW:0]     sumWide;
  logic [FW-1:0]          satAcc;
  logic                   satOvf;
  logic [FW-1:0]          dualAcc;
  logic                   dualOvf;

  // Full-width product for single mode and one product per half-width lane for dual mode.
  always_comb begin
    aExt     = {{DATA_W{multiplier[DATA_W-1]}}, multiplier};
    bExt     = {{DATA_W{multiplicand[DATA_W-1]}}, multiplicand};
    s1Prod_d = aExt * bExt;
    aLane[0] = {{H{multiplier[H-1]}}, multiplier[H-1:0]};
    bLane[0] = {{H{multiplicand[H-1]}}, multiplicand[H-1:0]};
    aLane[1] = {{H{multiplier[DATA_W-1]}}, multiplier[DATA_W-1:H]};
    bLane[1] = {{H{multiplicand[DATA_W-1]}}, multiplicand[DATA_W-1:H]};
    s1LaneProd_d[0] = aLane[0] * bLane[0];
    s1LaneProd_d[1] = aLane[1] * bLane[1];
  end

  // Single-lane sum is one bit wider so the saturating clamp can see true overflow.
  always_comb begin
    prodExt = {{(FW-2*DATA_W){s1Prod_q[2*DATA_W-1]}}, s1Prod_q};
    sumWide = {acc_q[FW-1], acc_q} + {prodExt[FW-1], prodExt};
    satOvf  = 1'b0;
    satAcc  = {{GUARD_W{sumWide[ACC_W-1]}}, sumWide[ACC_W-1:0]};
    if (sumWide > SAT_MAX) begin
      satAcc = {{(GUARD_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
      satOvf = 1'b1;
    end else if (sumWide < SAT_MIN) begin
      satAcc = {{(GUARD_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
      satOvf = 1'b1;
    end
  end

  // Each lane owns half of result and half of protect; nothing carries between lanes.
  always_comb begin
    logic [LW-1:0]      laneF;
    logic [LW-1:0]      laneP;
    logic signed [LW:0] laneWide;
    logic [LW-1:0]      laneNew;
    dualAcc = acc_q;
    dualOvf = 1'b0;
    for (int l = 0; l < 2; l++) begin
      laneF    = {acc_q[ACC_W + l*LG +: LG], acc_q[l*LA +: LA]};
      laneP    = {{(LW-DATA_W){s1LaneProd_q[l][DATA_W-1]}}, s1LaneProd_q[l]};
      laneWide = {laneF[LW-1], laneF} + {laneP[LW-1], laneP};
      laneNew  = laneF;
      case (s1Op_q)
        OP_DMUL: laneNew = laneP;
        OP_DMAC: laneNew = laneWide[LW-1:0];
        OP_DMACS: begin
          if (laneWide > LANE_MAX) begin
            laneNew = {{(LG+1){1'b0}}, {(LA-1){1'b1}}};
            dualOvf = 1'b1;
          end else if (laneWide < LANE_MIN) begin
            laneNew = {{(LG+1){1'b1}}, {(LA-1){1'b0}}};
            dualOvf = 1'b1;
          end else begin
            laneNew = {{LG{laneWide[LA-1]}}, laneWide[LA-1:0]};
          end
        end
        default: laneNew = laneF;
      endcase
      dualAcc[ACC_W + l*LG +: LG] = laneNew[LW-1:LA];
      dualAcc[l*LA +: LA]         = laneNew[LA-1:0];
    end
  end

  always_comb begin
    acc_d   = acc_q;
    s2Ovf_d = 1'b0;
    if (s1Valid_q) begin
      case (s1Op_q)
        OP_CLR, OP_CLR2: acc_d = '0;
        OP_MUL:          acc_d = prodExt;
        OP_MAC:          acc_d = sumWide[FW-1:0];
        OP_MACS: begin
          acc_d   = satAcc;
          s2Ovf_d = satOvf;
        end
        default: begin
          acc_d   = dualAcc;
          s2Ovf_d = dualOvf;
        end
      endcase
    end
  end

  // Stall freezes every stage at once; reset overrides stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid_q       <= 1'b0;
      s1Op_q          <= OP_CLR;
      s1Prod_q        <= '0;
      s1LaneProd_q[0] <= '0;
      s1LaneProd_q[1] <= '0;
      acc_q           <= '0;
      s2Valid_q       <= 1'b0;
      s2Ovf_q         <= 1'b0;
      result_q        <= '0;
      protect_q       <= '0;
      outValid_q      <= 1'b0;
      overflow_q      <= 1'b0;
    end else if (!stall) begin
      s1Valid_q       <= in_valid;
      s1Op_q          <= op_e'(instruction);
      s1Prod_q        <= s1Prod_d;
      s1LaneProd_q[0] <= s1LaneProd_d[0];
      s1LaneProd_q[1] <= s1LaneProd_d[1];
      acc_q           <= acc_d;
      s2Valid_q       <= s1Valid_q;
      s2Ovf_q         <= s2Ovf_d;
      result_q        <= acc_q[ACC_W-1:0];
      protect_q       <= acc_q[FW-1:ACC_W];
      outValid_q      <= s2Valid_q;
      overflow_q      <= s2Ovf_q;
    end
  end

  assign result    = result_q;
  assign protect   = protect_q;
  assign out_valid = outValid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Self-checking bench for mac_pipe: a reference model pushes expected outputs into a
// scoreboard queue as each op is driven; entries are popped as the pipeline delivers them.
module tb_mac_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        in_valid;
  logic [2:0]  instruction;
  logic [15:0] multiplier;
  logic [15:0] multiplicand;
  logic [31:0] result;
  logic [7:0]  protect;
  logic        out_valid;
  logic        overflow;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct {
    logic        v;
    logic [31:0] r;
    logic [7:0]  p;
    logic        o;
  } exp_t;

  exp_t        sb[$];
  exp_t        held;
  logic [39:0] modelF;
  longint      sumRef;

  mac_pipe #(.DATA_W(16), .ACC_W(32), .GUARD_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .in_valid     (in_valid),
    .instruction  (instruction),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .result       (result),
    .protect      (protect),
    .out_valid    (out_valid),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference arithmetic on plain integers, one lane or two.
  function automatic void modelStep(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic ov);
    longint f, p, s;
    logic [19:0] laneAcc;
    logic signed [7:0] la, lb;
    ov = 1'b0;
    if (op == 3'b000 || op == 3'b100) begin
      modelF = '0;
    end else if (!op[2]) begin
      f = longint'($signed(modelF));
      p = longint'($signed(a)) * longint'($signed(b));
      s = f + p;
      if (op[1:0] == 2'b01) s = p;
      if (op[1:0] == 2'b11) begin
        if (s > 64'sd2147483647) begin
          s = 64'sd2147483647; ov = 1'b1;
        end else if (s < -64'sd2147483648) begin
          s = -64'sd2147483648; ov = 1'b1;
        end
      end
      modelF = s[39:0];
    end else begin
      for (int l = 0; l < 2; l++) begin
        laneAcc = {modelF[32 + 4*l +: 4], modelF[16*l +: 16]};
        la = a[8*l +: 8];
        lb = b[8*l +: 8];
        f = longint'($signed(laneAcc));
        p = longint'(la) * longint'(lb);
        s = f + p;
        if (op[1:0] == 2'b01) s = p;
        if (op[1:0] == 2'b11) begin
          if (s > 64'sd32767) begin
            s = 64'sd32767; ov = 1'b1;
          end else if (s < -64'sd32768) begin
            s = -64'sd32768; ov = 1'b1;
          end
        end
        modelF[32 + 4*l +: 4] = s[19:16];
        modelF[16*l +: 16]    = s[15:0];
      end
    end
  endfunction

  task automatic resetScoreboard();
    exp_t z;
    z = '{v: 1'b0, r: 32'h0, p: 8'h0, o: 1'b0};
    sb.delete();
    modelF = '0;
    held   = z;
    sb.push_back(z);
    sb.push_back(z);
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic st, input logic v, input logic [2:0] op,
                               input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic ov;
    stall        = st;
    in_valid     = v;
    instruction  = op;
    multiplier   = a;
    multiplicand = b;
    if (!st) begin
      ov = 1'b0;
      if (v) modelStep(op, a, b, ov);
      e = '{v: v, r: modelF[31:0], p: modelF[39:32], o: ov};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (st) begin
      checkOutput("stall_valid", 64'(out_valid), 64'(held.v));
      checkOutput("stall_result", 64'(result), 64'(held.r));
      checkOutput("stall_protect", 64'(protect), 64'(held.p));
    end else if (sb.size() == 0) begin
      checkOutput("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      e    = sb.pop_front();
      held = e;
      checkOutput("out_valid", 64'(out_valid), 64'(e.v));
      checkOutput("result", 64'(result), 64'(e.r));
      checkOutput("protect", 64'(protect), 64'(e.p));
      if (e.v) checkOutput("overflow", 64'(overflow), 64'(e.o));
    end
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (2) applyStimulus(1'b0, 1'b0, 3'b000, 16'h0, 16'h0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; in_valid = 1'b0; instruction = 3'b000;
    multiplier = '0; multiplicand = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_result", 64'(result), 64'h0);
    checkOutput("reset_protect", 64'(protect), 64'h0);
    checkOutput("reset_valid", 64'(out_valid), 64'h0);
    checkOutput("reset_overflow", 64'(overflow), 64'h0);
    reset = 1'b0;
    resetScoreboard();

    applyStimulus(1'b0, 1'b1, 3'b000, 16'h0, 16'h0);
    applyStimulus(1'b0, 1'b1, 3'b001, 16'hFFFD, 16'h0007);
    drain();
    checkOutput("t1_result", 64'(result), 64'hFFFF_FFEB);
    checkOutput("t1_protect", 64'(protect), 64'hFF);

    applyStimulus(1'b0, 1'b1, 3'b100, 16'h0, 16'h0);
    repeat (8) applyStimulus(1'b0, 1'b1, 3'b010, 16'h4000, 16'h4000);
    drain();
    checkOutput("t2_result", 64'(result), 64'h8000_0000);
    checkOutput("t2_protect", 64'(protect), 64'h00);

    applyStimulus(1'b0, 1'b1, 3'b000, 16'h0, 16'h0);
    repeat (8) applyStimulus(1'b0, 1'b1, 3'b011, 16'h4000, 16'h4000);
    drain();
    checkOutput("t3_result", 64'(result), 64'h7FFF_FFFF);
    checkOutput("t3_overflow", 64'(overflow), 64'h1);

    applyStimulus(1'b0, 1'b1, 3'b000, 16'h0, 16'h0);
    applyStimulus(1'b0, 1'b1, 3'b101, 16'h03FE, 16'h0505);
    drain();
    checkOutput("t4_dmul_result", 64'(result), 64'h000F_FFF6);
    checkOutput("t4_dmul_protect", 64'(protect), 64'h0F);
    applyStimulus(1'b0, 1'b1, 3'b000, 16'h0, 16'h0);
    applyStimulus(1'b0, 1'b1, 3'b101, 16'h7F80, 16'h7F7F);
    repeat (2) applyStimulus(1'b0, 1'b1, 3'b111, 16'h7F80, 16'h7F7F);
    drain();
    checkOutput("t4_dmacs_result", 64'(result), 64'h7FFF_8000);
    checkOutput("t4_dmacs_overflow", 64'(overflow), 64'h1);

    // MAC stream with a three-cycle stall and two bubbles; stalled inputs are garbage.
    applyStimulus(1'b0, 1'b1, 3'b000, 16'h0, 16'h0);
    sumRef = 0;
    for (int i = 0; i < 14; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom_range(0, 2000)) - 16'd1000;
      b = 16'($urandom_range(0, 2000)) - 16'd1000;
      if (i >= 4 && i <= 6) begin
        applyStimulus(1'b1, 1'b1, 3'($urandom), 16'($urandom), 16'($urandom));
      end else if (i == 9 || i == 11) begin
        applyStimulus(1'b0, 1'b0, 3'b010, a, b);
      end else begin
        sumRef += longint'($signed(a)) * longint'($signed(b));
        applyStimulus(1'b0, 1'b1, 3'b010, a, b);
      end
    end
    drain();
    checkOutput("t5_sum", 64'(result), 64'(sumRef[31:0]));

    // Reset arrives asynchronously while two MACs are still in the pipe.
    applyStimulus(1'b0, 1'b1, 3'b010, 16'h0100, 16'h0100);
    applyStimulus(1'b0, 1'b1, 3'b010, 16'h0100, 16'h0100);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_async_result", 64'(result), 64'h0);
    checkOutput("t6_async_protect", 64'(protect), 64'h0);
    checkOutput("t6_async_valid", 64'(out_valid), 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    resetScoreboard();
    applyStimulus(1'b0, 1'b1, 3'b010, 16'd100, 16'd200);
    drain();
    checkOutput("t6_fresh", 64'(result), 64'd20000);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
